// File: rtl/mem_test_ctrl.sv
// Memory test sequencer: a write pass then a read-and-compare pass over an inclusive
// word window on an Avalon-MM master, with result counters and a finished level.
module mem_test_ctrl #(
    parameter int AMM_ADDR_W   = 26,
    parameter int AMM_DATA_W   = 32,
    parameter int MAX_RD_OUTST = 8
) (
    input  logic                  clk_mem_i,
    input  logic                  rst_n_i,
    input  logic                  test_start_i,
    input  logic [AMM_ADDR_W-1:0] start_addr_i,
    input  logic [AMM_ADDR_W-1:0] end_addr_i,
    input  logic [2:0]            mode_i,
    input  logic [AMM_DATA_W-1:0] set_data_i,
    output logic [AMM_ADDR_W-1:0] amm_address_o,
    output logic                  amm_write_o,
    output logic [AMM_DATA_W-1:0] amm_writedata_o,
    output logic                  amm_read_o,
    input  logic                  amm_waitrequest_i,
    input  logic                  amm_readdatavalid_i,
    input  logic [AMM_DATA_W-1:0] amm_readdata_i,
    output logic                  busy_o,
    output logic                  test_finished_o,
    output logic                  param_err_o,
    output logic [31:0]           err_cnt_o,
    output logic [31:0]           first_err_addr_o,
    output logic [31:0]           wr_cnt_o,
    output logic [31:0]           rd_cnt_o
);

    localparam int OW = $clog2(MAX_RD_OUTST) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [AMM_DATA_W-1:0] f_pattern(
        input logic [1:0]            sel,
        input logic [AMM_ADDR_W-1:0] a,
        input logic [AMM_DATA_W-1:0] d
    );
        logic [AMM_DATA_W-1:0] a_ext;
        a_ext = AMM_DATA_W'(a);
        case (sel)
            2'd0:    f_pattern = d;
            2'd1:    f_pattern = a_ext;
            2'd2:    f_pattern = ~a_ext;
            2'd3:    f_pattern = a[0] ? ~d : d;
            default: f_pattern = d;
        endcase
    endfunction

    state_t                r_state;
    logic [AMM_ADDR_W-1:0] r_start;
    logic [AMM_ADDR_W-1:0] r_end;
    logic [1:0]            r_pat;
    logic [AMM_DATA_W-1:0] r_set_data;
    logic [AMM_ADDR_W-1:0] r_addr;
    logic [AMM_ADDR_W-1:0] r_ret_addr;
    logic [OW-1:0]         r_outst;
    logic                  r_write;
    logic                  r_read;
    logic [AMM_DATA_W-1:0] r_wdata;
    logic                  r_busy;
    logic                  r_finished;
    logic                  r_param_err;
    logic [31:0]           r_err_cnt;
    logic [31:0]           r_first_err;
    logic [31:0]           r_wr_cnt;
    logic [31:0]           r_rd_cnt;

    logic                  w_accept;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_rdv;
    logic                  w_mismatch;
    logic                  w_rd_ok;
    logic [OW-1:0]         w_outst_nxt;
    logic [AMM_ADDR_W-1:0] w_addr_inc;
    logic [AMM_DATA_W-1:0] w_exp;

    assign w_accept   = test_start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_wr_acc   = r_write && !amm_waitrequest_i;
    assign w_rd_acc   = r_read && !amm_waitrequest_i;
    // Returns are only meaningful while reads of this run can still be in flight
    assign w_rdv      = amm_readdatavalid_i && (r_outst != {OW{1'b0}})
                        && ((r_state == ST_READ) || (r_state == ST_DRAIN));
    assign w_exp      = f_pattern(r_pat, r_ret_addr, r_set_data);
    assign w_mismatch = w_rdv && (amm_readdata_i != w_exp);
    assign w_addr_inc = r_addr + AMM_ADDR_W'(1);
    assign w_rd_ok    = (w_outst_nxt < OW'(MAX_RD_OUTST));

    // Next outstanding-read count from this cycle's accept and return
    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_rd_acc, w_rdv})
            2'b10:   w_outst_nxt = r_outst + OW'(1);
            2'b01:   w_outst_nxt = r_outst - OW'(1);
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Sequencer FSM, bus outputs, compare and result counters
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_start     <= '0;
            r_end       <= '0;
            r_pat       <= 2'd0;
            r_set_data  <= '0;
            r_addr      <= '0;
            r_ret_addr  <= '0;
            r_outst     <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
            r_param_err <= 1'b0;
            r_err_cnt   <= 32'd0;
            r_first_err <= 32'd0;
            r_wr_cnt    <= 32'd0;
            r_rd_cnt    <= 32'd0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_rdv) begin
                r_ret_addr <= r_ret_addr + AMM_ADDR_W'(1);
            end
            if (w_mismatch) begin
                if (r_err_cnt != 32'hFFFF_FFFF) begin
                    r_err_cnt <= r_err_cnt + 32'd1;
                end
                if (r_err_cnt == 32'd0) begin
                    r_first_err <= 32'(r_ret_addr);
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_start     <= start_addr_i;
                        r_end       <= end_addr_i;
                        r_pat       <= mode_i[1:0];
                        r_set_data  <= set_data_i;
                        r_addr      <= start_addr_i;
                        r_ret_addr  <= start_addr_i;
                        r_err_cnt   <= 32'd0;
                        r_first_err <= 32'd0;
                        r_wr_cnt    <= 32'd0;
                        r_rd_cnt    <= 32'd0;
                        if (start_addr_i > end_addr_i) begin
                            r_state     <= ST_DONE;
                            r_param_err <= 1'b1;
                            r_finished  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state     <= mode_i[2] ? ST_READ : ST_WRITE;
                            r_param_err <= 1'b0;
                            r_finished  <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!r_write) begin
                        r_write <= 1'b1;
                        r_wdata <= f_pattern(r_pat, r_addr, r_set_data);
                    end else if (w_wr_acc) begin
                        r_wr_cnt <= r_wr_cnt + 32'd1;
                        // End compare precedes increment so a top-of-space window cannot wrap
                        if (r_addr == r_end) begin
                            r_write <= 1'b0;
                            r_addr  <= r_start;
                            r_state <= ST_READ;
                        end else begin
                            r_addr  <= w_addr_inc;
                            r_wdata <= f_pattern(r_pat, w_addr_inc, r_set_data);
                        end
                    end
                end
                ST_READ: begin
                    if (!r_read) begin
                        r_read <= w_rd_ok;
                    end else if (w_rd_acc) begin
                        r_rd_cnt <= r_rd_cnt + 32'd1;
                        if (r_addr == r_end) begin
                            r_read  <= 1'b0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_addr <= w_addr_inc;
                            r_read <= w_rd_ok;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_outst == {OW{1'b0}}) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_write <= 1'b0;
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign amm_address_o    = r_addr;
    assign amm_write_o      = r_write;
    assign amm_writedata_o  = r_wdata;
    assign amm_read_o       = r_read;
    assign busy_o           = r_busy;
    assign test_finished_o  = r_finished;
    assign param_err_o      = r_param_err;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_err;
    assign wr_cnt_o         = r_wr_cnt;
    assign rd_cnt_o         = r_rd_cnt;

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Scoreboard bench for mem_test_ctrl: a behavioural Avalon-MM slave with stalls,
// read latency and data corruption; expected transfers are queued per run.
module tb_mem_test_ctrl;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_start_i = 1'b0;
    logic [AW-1:0] start_addr_i = '0;
    logic [AW-1:0] end_addr_i = '0;
    logic [2:0]    mode_i = 3'd0;
    logic [31:0]   set_data_i = 32'd0;
    logic [AW-1:0] amm_address_o;
    logic          amm_write_o;
    logic [31:0]   amm_writedata_o;
    logic          amm_read_o;
    logic          amm_waitrequest_i = 1'b0;
    logic          amm_readdatavalid_i = 1'b0;
    logic [31:0]   amm_readdata_i = 32'd0;
    logic          busy_o;
    logic          test_finished_o;
    logic          param_err_o;
    logic [31:0]   err_cnt_o;
    logic [31:0]   first_err_addr_o;
    logic [31:0]   wr_cnt_o;
    logic [31:0]   rd_cnt_o;

    mem_test_ctrl #(.AMM_ADDR_W(AW), .AMM_DATA_W(32), .MAX_RD_OUTST(8)) dut (
        .clk_mem_i(clk), .rst_n_i(rst_n), .test_start_i(test_start_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .mode_i(mode_i),
        .set_data_i(set_data_i), .amm_address_o(amm_address_o), .amm_write_o(amm_write_o),
        .amm_writedata_o(amm_writedata_o), .amm_read_o(amm_read_o),
        .amm_waitrequest_i(amm_waitrequest_i), .amm_readdatavalid_i(amm_readdatavalid_i),
        .amm_readdata_i(amm_readdata_i), .busy_o(busy_o), .test_finished_o(test_finished_o),
        .param_err_o(param_err_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
        .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] a; logic [31:0] d;} xact_t;
    typedef struct {logic [31:0] a; int ready;} pend_t;

    xact_t       exp_wr[$];
    xact_t       obs_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] obs_rd[$];
    pend_t       pend[$];
    logic [31:0] mem[int];
    logic [31:0] corrupt[int];

    int          cyc = 0;
    int          lat = 1;
    bit          wait_rand = 1'b0;
    int          mon_outst = 0;
    int          max_outst = 0;
    int          outst_viol = 0;
    int          hold_viol = 0;
    bit          prev_stall = 1'b0;
    logic        prev_w, prev_r;
    logic [AW-1:0] prev_a;
    logic [31:0] prev_d;
    int          strobe_cyc = 0;
    int          first_acc_cyc = 0;
    bit          seen_first = 1'b0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] tb_pat(input logic [1:0] sel, input logic [31:0] a,
                                           input logic [31:0] d);
        case (sel)
            2'd0:    return d;
            2'd1:    return a;
            2'd2:    return ~a;
            default: return a[0] ? ~d : d;
        endcase
    endfunction

    // Bus monitor: records accepted transfers, checks stall hold and read limit
    always @(posedge clk) begin
        if (!rst_n) begin
            mon_outst  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (amm_write_o !== prev_w || amm_read_o !== prev_r ||
                amm_address_o !== prev_a || (prev_w && amm_writedata_o !== prev_d)))
                hold_viol++;
            if (amm_write_o && amm_read_o) hold_viol++;
            if (test_start_i) begin
                strobe_cyc = cyc;
                seen_first = 1'b0;
            end
            if (amm_read_o && mon_outst >= 8) outst_viol++;
            if ((amm_write_o || amm_read_o) && !amm_waitrequest_i && !seen_first) begin
                first_acc_cyc = cyc;
                seen_first = 1'b1;
            end
            if (amm_write_o && !amm_waitrequest_i) begin
                obs_wr.push_back('{a: 32'(amm_address_o), d: amm_writedata_o});
                mem[int'(amm_address_o)] = amm_writedata_o;
            end
            if (amm_read_o && !amm_waitrequest_i) begin
                obs_rd.push_back(32'(amm_address_o));
                pend.push_back('{a: 32'(amm_address_o), ready: cyc + lat});
                mon_outst++;
            end
            if (amm_readdatavalid_i && mon_outst > 0) mon_outst--;
            if (mon_outst > max_outst) max_outst = mon_outst;
            prev_stall = (amm_write_o || amm_read_o) && amm_waitrequest_i;
            prev_w = amm_write_o;
            prev_r = amm_read_o;
            prev_a = amm_address_o;
            prev_d = amm_writedata_o;
        end
        cyc++;
    end

    // Slave response driver: random stalls and in-order read returns after latency
    always @(negedge clk) begin : slave_drv
        pend_t p;
        int    k;
        amm_waitrequest_i = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
            p = pend.pop_front();
            k = int'(p.a);
            amm_readdatavalid_i = 1'b1;
            amm_readdata_i = (mem.exists(k) ? mem[k] : 32'd0) ^
                             (corrupt.exists(k) ? corrupt[k] : 32'd0);
        end else begin
            amm_readdatavalid_i = 1'b0;
            amm_readdata_i = 32'd0;
        end
    end

    task automatic run_and_score(input string name, input logic [31:0] s, input logic [31:0] e,
                                 input logic [2:0] mode, input logic [31:0] sd,
                                 input logic [31:0] exp_err, input logic [31:0] exp_first,
                                 input bit busy_pulse);
        int    n_wr, n_rd, guard;
        xact_t xe, xo;
        logic [31:0] re, ro;
        exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
        for (logic [32:0] a = 33'(s); a <= 33'(e); a++) begin
            if (!mode[2]) exp_wr.push_back('{a: a[31:0], d: tb_pat(mode[1:0], a[31:0], sd)});
            exp_rd.push_back(a[31:0]);
        end
        n_wr = exp_wr.size();
        n_rd = exp_rd.size();
        @(negedge clk);
        start_addr_i = AW'(s); end_addr_i = AW'(e); mode_i = mode; set_data_i = sd;
        test_start_i = 1'b1;
        @(negedge clk);
        test_start_i = 1'b0;
        if (busy_pulse) begin
            repeat (2) @(negedge clk);
            total++;
            if (busy_o !== 1'b1) begin
                bad++; $display("FAIL %s busy_at_pulse got=%b want=1", name, busy_o);
            end
            start_addr_i = '0; end_addr_i = AW'(32'h3F); mode_i = 3'd6;
            test_start_i = 1'b1;
            @(negedge clk);
            test_start_i = 1'b0;
        end
        guard = 0;
        while (!test_finished_o && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 3000) begin
            bad++; $display("FAIL %s timeout finished=%b want=1", name, test_finished_o);
        end
        total++;
        if (obs_wr.size() != n_wr || obs_rd.size() != n_rd) begin
            bad++;
            $display("FAIL %s xfer_count got wr=%0d rd=%0d want wr=%0d rd=%0d", name,
                     obs_wr.size(), obs_rd.size(), n_wr, n_rd);
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            xe = exp_wr.pop_front();
            xo = obs_wr.pop_front();
            total++;
            if (xo.a !== xe.a || xo.d !== xe.d) begin
                bad++;
                $display("FAIL %s write got a=%h d=%h want a=%h d=%h", name, xo.a, xo.d, xe.a, xe.d);
            end
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            re = exp_rd.pop_front();
            ro = obs_rd.pop_front();
            total++;
            if (ro !== re) begin
                bad++; $display("FAIL %s read_addr got=%h want=%h", name, ro, re);
            end
        end
        total++;
        if (wr_cnt_o !== 32'(n_wr) || rd_cnt_o !== 32'(n_rd)) begin
            bad++;
            $display("FAIL %s counters got wr=%0d rd=%0d want wr=%0d rd=%0d", name,
                     wr_cnt_o, rd_cnt_o, n_wr, n_rd);
        end
        total++;
        if (err_cnt_o !== exp_err || first_err_addr_o !== exp_first) begin
            bad++;
            $display("FAIL %s errors got cnt=%0d first=%h want cnt=%0d first=%h", name,
                     err_cnt_o, first_err_addr_o, exp_err, exp_first);
        end
        total++;
        if (busy_o !== 1'b0 || param_err_o !== 1'b0) begin
            bad++; $display("FAIL %s done_flags got busy=%b perr=%b want 0 0", name, busy_o, param_err_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy_o, test_finished_o, param_err_o, amm_write_o, amm_read_o, amm_address_o,
             amm_writedata_o, err_cnt_o, first_err_addr_o, wr_cnt_o, rd_cnt_o} !== '0) begin
            bad++;
            $display("FAIL reset outputs got busy=%b fin=%b wr=%b rd=%b wcnt=%0d rcnt=%0d want all 0",
                     busy_o, test_finished_o, amm_write_o, amm_read_o, wr_cnt_o, rd_cnt_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        lat = 1; wait_rand = 1'b0;
        run_and_score("basic", 32'h10, 32'h13, 3'd1, 32'd0, 32'd0, 32'd0, 1'b0);
        total++;
        if (first_acc_cyc - strobe_cyc < 2) begin
            bad++; $display("FAIL basic first_xfer_latency got=%0d want>=2", first_acc_cyc - strobe_cyc);
        end
        total++;
        if (test_finished_o !== 1'b1) begin
            bad++; $display("FAIL basic finished got=%b want=1", test_finished_o);
        end
    endtask

    task automatic test_stall();
        hold_viol = 0; outst_viol = 0; max_outst = 0;
        lat = 3; wait_rand = 1'b1;
        run_and_score("stall", 32'h10, 32'h13, 3'd1, 32'd0, 32'd0, 32'd0, 1'b0);
        lat = 12; wait_rand = 1'b0;
        run_and_score("deep", 32'h0, 32'h1F, 3'd3, 32'h1234_5678, 32'd0, 32'd0, 1'b0);
        total++;
        if (hold_viol != 0 || outst_viol != 0) begin
            bad++; $display("FAIL stall bus_rules got hold=%0d outst=%0d want 0 0", hold_viol, outst_viol);
        end
        total++;
        if (max_outst != 8) begin
            bad++; $display("FAIL stall max_outstanding got=%0d want=8", max_outst);
        end
    endtask

    task automatic test_compare();
        lat = 2; wait_rand = 1'b0;
        corrupt[32'h12] = 32'h0000_0001;
        run_and_score("cmp1", 32'h10, 32'h13, 3'd0, 32'hA5A5_A5A5, 32'd1, 32'h12, 1'b0);
        corrupt[32'h13] = 32'h0000_0100;
        run_and_score("cmp2", 32'h10, 32'h13, 3'd0, 32'hA5A5_A5A5, 32'd2, 32'h12, 1'b0);
        corrupt.delete();
    endtask

    task automatic test_param_err();
        exp_wr.delete(); obs_wr.delete(); obs_rd.delete();
        @(negedge clk);
        start_addr_i = AW'(32'h20); end_addr_i = AW'(32'h1F); mode_i = 3'd1;
        test_start_i = 1'b1;
        @(negedge clk);
        test_start_i = 1'b0;
        total++;
        if (param_err_o !== 1'b1 || test_finished_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL param_err flags got perr=%b fin=%b busy=%b want 1 1 0",
                     param_err_o, test_finished_o, busy_o);
        end
        repeat (5) @(negedge clk);
        total++;
        if (obs_wr.size() != 0 || obs_rd.size() != 0 || wr_cnt_o !== 32'd0 || rd_cnt_o !== 32'd0) begin
            bad++;
            $display("FAIL param_err bus_idle got xw=%0d xr=%0d wcnt=%0d rcnt=%0d want 0",
                     obs_wr.size(), obs_rd.size(), wr_cnt_o, rd_cnt_o);
        end
    endtask

    task automatic test_busy_start();
        lat = 3; wait_rand = 1'b1;
        run_and_score("busy_start", 32'h10, 32'h13, 3'd1, 32'd0, 32'd0, 32'd0, 1'b1);
        wait_rand = 1'b0;
    endtask

    task automatic test_readonly_reset();
        int guard;
        mem.delete();
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'hFFFF_FFFE;
        lat = 2;
        run_and_score("readonly", 32'h0, 32'h1, 3'd6, 32'd0, 32'd0, 32'd0, 1'b0);
        lat = 3;
        @(negedge clk);
        start_addr_i = '0; end_addr_i = AW'(32'h3F); mode_i = 3'd6;
        test_start_i = 1'b1;
        @(negedge clk);
        test_start_i = 1'b0;
        guard = 0;
        while (!amm_read_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy_o, test_finished_o, param_err_o, amm_write_o, amm_read_o, amm_address_o,
             err_cnt_o, first_err_addr_o, wr_cnt_o, rd_cnt_o} !== '0 || guard >= 20) begin
            bad++;
            $display("FAIL reset_mid_read got busy=%b rd=%b rcnt=%0d guard=%0d want all 0",
                     busy_o, amm_read_o, rd_cnt_o, guard);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || rd_cnt_o !== 32'd0 || err_cnt_o !== 32'd0 || test_finished_o !== 1'b0) begin
            bad++;
            $display("FAIL stale_data got busy=%b rcnt=%0d err=%0d fin=%b want 0",
                     busy_o, rd_cnt_o, err_cnt_o, test_finished_o);
        end
        lat = 1;
        run_and_score("after_reset", 32'h10, 32'h13, 3'd1, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_compare();
        test_param_err();
        test_busy_start();
        test_readonly_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_test_ctrl.md
Name: mem_test_ctrl

Overview:
Sequencer for the memory checker's test run. It lives in the memory clock domain, downstream of the CSR block. On a start strobe it latches the test parameters, then drives an Avalon-MM master through a write pass and a read-and-compare pass over an inclusive address window. It collects result counters and raises a finished level that the CSR block synchronises back to the system domain.

Parameters:
AMM_ADDR_W, 26, Avalon-MM word address width (≤ 32)
AMM_DATA_W, 32, Avalon-MM data width (fixed 32 for this revision)
MAX_RD_OUTST, 8, maximum outstanding read requests (power of two, ≥ 2)

Ports:
clk_mem_i  in  1  memory-domain clock; sole clock of the block
rst_n_i  in  1  asynchronous active-low reset
test_start_i  in  1  one-cycle start strobe (already synchronised)
start_addr_i  in  AMM_ADDR_W  first word address
end_addr_i  in  AMM_ADDR_W  last word address, inclusive
mode_i  in  3  [1:0] pattern select; [2] read-only (skip write pass)
set_data_i  in  32  user data word for patterns 0 and 3
amm_address_o  out  AMM_ADDR_W  master address
amm_write_o  out  1  write request
amm_writedata_o  out  32  write data
amm_read_o  out  1  read request
amm_waitrequest_i  in  1  slave stall
amm_readdatavalid_i  in  1  read data valid
amm_readdata_i  in  32  read data
busy_o  out  1  test in progress
test_finished_o  out  1  level; high from run completion until next accepted start
param_err_o  out  1  last start had start_addr > end_addr
err_cnt_o  out  32  mismatch count, saturating at 0xFFFFFFFF
first_err_addr_o  out  32  zero-extended address of first mismatch; 0 if none
wr_cnt_o  out  32  accepted write transactions
rd_cnt_o  out  32  accepted read transactions

Behaviour:
- Clock and reset: one clock, clk_mem_i. Reset is asynchronous and active-low (rst_n_i).
- Reset values: all outputs 0. State is IDLE.
- Start acceptance:
  - test_start_i is accepted only in IDLE or DONE. It is ignored while busy.
  - On accept, parameters are latched into internal registers. All counters, param_err_o, first_err_addr_o and test_finished_o clear on the next cycle.
- Patterns (expected/write data as a function of word address A, zero-extended to 32 bits):
  - 0: set_data
  - 1: A
  - 2: ~A
  - 3: A[0] ? ~set_data : set_data
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE/DONE → WRITE on accept, or → READ if mode[2]=1.
  - If start_addr > end_addr: → DONE directly. param_err_o=1, counters stay 0, no bus activity.
  - WRITE:
    - amm_write_o=1 with address and data for the current address.
    - Address advances only in a cycle with write=1 and waitrequest=0.
    - Acceptance at end_addr → READ, with the address reloaded to start_addr.
  - READ:
    - amm_read_o=1 while outstanding < MAX_RD_OUTST. amm_read_o deasserts when outstanding = MAX_RD_OUTST.
    - Address advances on read=1 and waitrequest=0.
    - Acceptance at end_addr → DRAIN.
  - DRAIN: no requests. Waits for outstanding = 0 → DONE.
  - DONE: test_finished_o=1, busy_o=0. Holds until the next accepted start.
- busy_o=1 in WRITE, READ and DRAIN.
- Bus outputs hold stable while waitrequest=1. write and read are never both asserted.
- Outstanding counter:
  - +1 on read accept, −1 on readdatavalid. Both in the same cycle: no change.
  - Width is log2(MAX_RD_OUTST)+1.
- Compare:
  - Reads return in order. A return-address register starts at start_addr and increments on each readdatavalid.
  - readdata is compared to pattern(return address) in the same cycle.
  - On mismatch, err_cnt_o increments (saturating). If this is the first error of the run, first_err_addr_o latches the return address.
- Counters: wr_cnt_o and rd_cnt_o increment on each accepted request. They wrap modulo 2^32; the wrap is not reachable with AMM_ADDR_W ≤ 31.
- Address arithmetic: a window ending at 2^AMM_ADDR_W−1 must terminate via the end_addr compare, not via overflow. The compare is done before the increment.
- readdatavalid outside READ/DRAIN (spurious) is ignored. It is not counted and not compared.
- Asynchronous reset mid-run aborts immediately to IDLE. Bus requests drop in the same instant. Read data still in flight after reset is ignored.

Test Plan:
- Start 0x10, end 0x13, mode 1, zero-wait slave → 4 writes with data 0x10..0x13, then 4 reads. wr_cnt=4, rd_cnt=4, err_cnt=0, test_finished_o high; first transfer no earlier than 2 cycles after the strobe.
- Same run with random waitrequest and a 3-cycle read latency → address/data held during stalls, never more than 8 reads outstanding, identical final counts.
- mode 0, set_data 0xA5A5A5A5, slave corrupts address 0x12 → err_cnt=1, first_err_addr=0x12; a second corruption at 0x13 leaves first_err_addr at 0x12 and gives err_cnt=2.
- start 0x20, end 0x1F → no bus activity, param_err_o=1, test_finished_o=1 within 2 cycles; test_start_i pulsed while busy in another run → ignored, counts unchanged.
- mode 6 (read-only, pattern 2) over 0x0..0x1 → zero writes, reads compared against 0xFFFFFFFF and 0xFFFFFFFE; rst_n_i low during READ → all outputs 0 and state IDLE, the next start runs cleanly.
